// File: rtl/mult_booth_r4_pkg.sv
// mult_booth_r4 shared types: op/state/select enums and operand extension.
// Optional build macro used by the top: MULT_ZERO_BYPASS_EN.
package mult_pkg;

    // Widest XLEN the generic extension helper supports.
    localparam int MAX_XLEN = 128;
    localparam int EXT_MAX  = MAX_XLEN + 2;

    typedef enum logic [1:0] {
        MUL_LO  = 2'b00,
        MULH_SS = 2'b01,
        MULH_SU = 2'b10,
        MULH_UU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

    typedef enum logic [2:0] {
        SEL_ZERO,
        SEL_PM,
        SEL_P2M,
        SEL_NM,
        SEL_N2M
    } sel_e;

    // Extend the low 'width' bits of value to EXT_MAX bits.
    function automatic logic [EXT_MAX-1:0] ext_operand(
        input logic [EXT_MAX-1:0] value,
        input int                 width,
        input logic               signed_flag
    );
        logic [EXT_MAX-1:0] mask;
        logic [EXT_MAX-1:0] tmp;
        logic               fill;
        mask = {EXT_MAX{1'b1}} << width;
        tmp  = value >> (width - 1);
        fill = signed_flag & tmp[0];
        return (value & ~mask) | (fill ? mask : '0);
    endfunction

    // MUL low half is signedness-independent; treat it as signed.
    function automatic logic rs1_signed(input op_e op);
        return op != MULH_UU;
    endfunction

    function automatic logic rs2_signed(input op_e op);
        return (op == MUL_LO) || (op == MULH_SS);
    endfunction

endpackage

// File: rtl/mult_booth_r4_if.sv
// Issue/result bundle between the execute-stage issuer and the multiplier.
// Master drives the request; slave returns status and rd.
interface mult_booth_r4_if #(
    parameter int XLEN = 32
);

    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            in_ready;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] rd;

    modport master (
        output start, op, rs1, rs2,
        input  in_ready, busy, done, rd
    );

    modport slave (
        input  start, op, rs1, rs2,
        output in_ready, busy, done, rd
    );

endinterface

// File: rtl/mult_booth_r4_digit.sv
// Radix-4 Booth digit: maps a 3-bit window and multiplicand M
// to the signed addend 0, +-M or +-2M at XLEN+3 bits.
module booth_r4_digit
    import mult_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int EXT_W = XLEN + 2,
    localparam int ADD_W = XLEN + 3
) (
    input  logic [2:0]       bits_i,
    input  logic [EXT_W-1:0] m_i,
    output logic [ADD_W-1:0] addend_o
);

    sel_e             sel;
    logic [ADD_W-1:0] m1;
    logic [ADD_W-1:0] m2;

    assign m1 = {m_i[EXT_W-1], m_i};
    assign m2 = {m_i, 1'b0};

    // Decode the Booth window into a select.
    always_comb begin
        sel = SEL_ZERO;
        unique case (bits_i)
            3'b001, 3'b010: sel = SEL_PM;
            3'b011:         sel = SEL_P2M;
            3'b100:         sel = SEL_N2M;
            3'b101, 3'b110: sel = SEL_NM;
            default:        sel = SEL_ZERO;
        endcase
    end

    // Form the two's-complement addend for the select.
    always_comb begin
        addend_o = '0;
        unique case (sel)
            SEL_PM:  addend_o = m1;
            SEL_P2M: addend_o = m2;
            SEL_NM:  addend_o = -m1;
            SEL_N2M: addend_o = -m2;
            default: addend_o = '0;
        endcase
    end

endmodule

// File: rtl/mult_booth_r4.sv
// Iterative radix-4 Booth multiplier for MUL/MULH/MULHSU/MULHU.
// Build macro: MULT_ZERO_BYPASS_EN (zero operand skips CALC).
module mult_booth_r4
    import mult_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic             clk,
    input logic             reset,
    mult_booth_r4_if.slave  bus
);

    localparam int NDIG  = XLEN / 2 + 1;
    localparam int CNT_W = $clog2(NDIG + 1);
    localparam int EXT_W = XLEN + 2;
    localparam int ADD_W = XLEN + 3;
    localparam int P_W   = 2 * EXT_W + 1;
    localparam int CAT_W = 2 * EXT_W + 2;

    state_e            state_q;
    op_e               op_q;
    logic [EXT_W-1:0]  m_q;
    logic [P_W-1:0]    p_q;
    logic [P_W-1:0]    p_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              in_ready_q;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   rd_q;

    op_e               op_in;
    logic [EXT_W-1:0]  a_ext;
    logic [EXT_W-1:0]  b_ext;
    logic [P_W-1:0]    p_load;
    logic [ADD_W-1:0]  addend;
    logic [ADD_W-1:0]  sum;
    logic [CAT_W-1:0]  cat;
    logic signed [CAT_W-1:0] shifted;
    logic [XLEN-1:0]   res;
    logic              last_dig;
    logic              zero_byp;

    assign op_in = op_e'(bus.op);

    // Extend the incoming operands and build the accumulator load value.
    always_comb begin
        a_ext  = EXT_W'(ext_operand(EXT_MAX'(bus.rs1), XLEN,
                                    rs1_signed(op_in)));
        b_ext  = EXT_W'(ext_operand(EXT_MAX'(bus.rs2), XLEN,
                                    rs2_signed(op_in)));
        p_load = {{EXT_W{1'b0}}, b_ext, 1'b0};
    end

    booth_r4_digit #(
        .XLEN (XLEN)
    ) u_digit (
        .bits_i   (p_q[2:0]),
        .m_i      (m_q),
        .addend_o (addend)
    );

    // One Booth step: add the digit into hi, then shift P right by 2.
    always_comb begin
        sum     = {p_q[P_W-1], p_q[P_W-1:EXT_W+1]} + addend;
        cat     = {sum, p_q[EXT_W:0]};
        shifted = $signed(cat) >>> 2;
        p_d     = P_W'(shifted);
        res     = (op_q == MUL_LO) ? p_d[XLEN:1] : p_d[2*XLEN:XLEN+1];
    end

    assign last_dig = (cnt_q == CNT_W'(NDIG - 1));

`ifdef MULT_ZERO_BYPASS_EN
    assign zero_byp = (bus.rs1 == '0) || (bus.rs2 == '0);
`else
    assign zero_byp = 1'b0;
`endif

    // Control FSM with registered status outputs and result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            op_q       <= MUL_LO;
            m_q        <= '0;
            p_q        <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_q       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start && in_ready_q) begin
                        op_q       <= op_in;
                        m_q        <= a_ext;
                        p_q        <= p_load;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        if (zero_byp) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            rd_q    <= '0;
                        end else begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    p_q <= p_d;
                    if (cnt_q != CNT_W'(NDIG))
                        cnt_q <= cnt_q + 1'b1;
                    if (last_dig) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        rd_q    <= res;
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    done_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rd       = rd_q;

endmodule

// File: tb/tb_mult_booth_r4.sv
// Randomised and directed bench for mult_booth_r4 (XLEN=32)
// against a wide-integer reference of the RV multiply group.
module tb_mult_booth_r4;

    localparam int XLEN = 32;
    localparam int NDIG = XLEN / 2 + 1;
`ifdef MULT_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mult_booth_r4_if #(.XLEN(XLEN)) bus ();

    mult_booth_r4 #(
        .XLEN (XLEN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Full product of the extended operands, then pick the half.
    function automatic logic [31:0] model(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [127:0] wa, wb, pr;
        bit sa, sb;
        sa = (o != 2'b11);
        sb = (o == 2'b00) || (o == 2'b01);
        wa = sa ? {{96{a[31]}}, a} : {96'b0, a};
        wb = sb ? {{96{b[31]}}, b} : {96'b0, b};
        pr = wa * wb;
        return (o == 2'b00) ? pr[31:0] : pr[63:32];
    endfunction

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
        return (BYP && (a == 0 || b == 0)) ? 1 : NDIG + 1;
    endfunction

    function automatic int exp_busy(input logic [31:0] a, input logic [31:0] b);
        return (BYP && (a == 0 || b == 0)) ? 0 : NDIG;
    endfunction

    task automatic wait_ready();
        int g = 0;
        while (!bus.in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) check("ready_timeout", 32'(bus.in_ready), 32'd1);
    endtask

    // Issue one op; report rd, start-to-done cycles and busy cycles.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] r,
                          output int lat, output int bz);
        wait_ready();
        bus.op    = o;
        bus.rs1   = a;
        bus.rs2   = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        bz  = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) bz++;
            @(negedge clk);
            lat++;
        end
        r = bus.rd;
    endtask

    task automatic run_chk(input string tag, input logic [1:0] o,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        logic [31:0] r;
        int lat, bz;
        run_op(o, a, b, r, lat, bz);
        check({tag, "_rd"}, r, exp);
        check({tag, "_lat"}, lat, exp_lat(a, b));
        check({tag, "_busy"}, bz, exp_busy(a, b));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] corners [5];
        logic [31:0] a, b;
        logic [1:0]  o;
        int cyc, pulses;

        corners[0] = 32'h0;
        corners[1] = 32'h1;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.rs1   = '0;
        bus.rs2   = '0;
        reset     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rd", bus.rd, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_chk("mul_7_m3", 2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_chk("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000,
                32'h4000_0000);
        run_chk("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'hFFFF_FFFE);
        run_chk("mulhsu_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'hFFFF_FFFF);
        run_chk("mul_m1m1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);

        // start held through CALC/DONE with changing operands
        wait_ready();
        bus.op    = 2'b00;
        bus.rs1   = 32'd6;
        bus.rs2   = 32'd7;
        bus.start = 1'b1;
        @(negedge clk);
        bus.rs1 = 32'd9;
        bus.rs2 = 32'd11;
        cyc = 1;
        while (!bus.done && cyc < 100) begin
            if (cyc == 3) check("hold_ready_calc", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
            cyc++;
        end
        check("hold_lat", cyc, NDIG + 1);
        check("hold_rd", bus.rd, 32'd42);
        check("hold_ready_done", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("hold_idle_ready", 32'(bus.in_ready), 32'd1);
        check("hold_idle_busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_rd_kept", bus.rd, 32'd42);
        run_chk("after_hold", 2'b00, 32'd9, 32'd11, 32'd99);

        // reset in the 5th CALC cycle aborts the op
        wait_ready();
        bus.op    = 2'b00;
        bus.rs1   = 32'd12345;
        bus.rs2   = 32'd678;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (cyc < 5) begin
            @(negedge clk);
            cyc++;
        end
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(bus.in_ready), 32'd1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_rd", bus.rd, 32'd0);
        reset  = 1'b1;
        pulses = 0;
        repeat (25) begin
            if (bus.done) pulses++;
            @(negedge clk);
        end
        check("abort_no_done", pulses, 0);
        run_chk("mul_3x5", 2'b00, 32'd3, 32'd5, 32'd15);

        run_chk("zero_rs1", 2'b00, 32'd0, 32'h1234, 32'd0);

        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)]
                                            : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)]
                                            : $urandom;
            run_chk("rand", o, a, b, model(o, a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
